// File: rtl/updown_mod_counter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// updown_mod_counter : modulo-N up/down counter with clear, load, tc and wrap.
// Macro COUNTER_SATURATE_EN: hold at the bounds instead of wrapping.
// Rev 1.0
// =============================================================================
module updown_mod_counter #(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] q_o,
   output logic             tc_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
`ifdef COUNTER_SATURATE_EN
   localparam logic [WIDTH-1:0] UP_NEXT   = MAX_VAL;
   localparam logic [WIDTH-1:0] DOWN_NEXT = '0;
`else
   localparam logic [WIDTH-1:0] UP_NEXT   = '0;
   localparam logic [WIDTH-1:0] DOWN_NEXT = MAX_VAL;
`endif

   generate
      if (WIDTH < 32'd1 || WIDTH > 32'd32 || MODULUS < 64'd2 ||
          MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
         $error("updown_mod_counter: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             at_max, at_zero, at_bound;

   assign at_max   = (count_q == MAX_VAL);
   assign at_zero  = (count_q == '0);
   // tc doubles as the "next enabled step crosses a bound" condition
   assign at_bound = en_i & (up_i ? at_max : at_zero);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = (din_i > MAX_VAL) ? MAX_VAL : din_i;
      end else if (en_i) begin
         wrap_d = at_bound;
         if (up_i) begin
            count_d = at_max ? UP_NEXT : count_q + ONE;
         end else begin
            count_d = at_zero ? DOWN_NEXT : count_q - ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign q_o    = count_q;
   assign tc_o   = at_bound;
   assign wrap_o = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_updown_mod_counter : randomized and directed bench for three counter
// configurations (10/4b, 8/3b, 2/1b) against an arithmetic reference model.
// Rev 1.0
// =============================================================================
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       reset, clr, load, en, up;
   logic [3:0] din;
   logic [3:0] q0;
   logic [2:0] q1;
   logic [0:0] q2;
   logic       tc0, tc1, tc2, w0, w1, w2;

   int checks = 0;
   int errors = 0;
   int MODS[3] = '{10, 8, 2};
   int WIDS[3] = '{4, 3, 1};
   int mq[3];
   bit mw[3];

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut0 (
      .clk(clk), .reset(reset), .clr_i(clr), .load_i(load), .din_i(din),
      .en_i(en), .up_i(up), .q_o(q0), .tc_o(tc0), .wrap_o(w0));
   updown_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut1 (
      .clk(clk), .reset(reset), .clr_i(clr), .load_i(load), .din_i(din[2:0]),
      .en_i(en), .up_i(up), .q_o(q1), .tc_o(tc1), .wrap_o(w1));
   updown_mod_counter #(.WIDTH(1), .MODULUS(2)) u_dut2 (
      .clk(clk), .reset(reset), .clr_i(clr), .load_i(load), .din_i(din[0:0]),
      .en_i(en), .up_i(up), .q_o(q2), .tc_o(tc2), .wrap_o(w2));

   function automatic logic [31:0] act_q(int i);
      case (i)
         0:       return {28'd0, q0};
         1:       return {29'd0, q1};
         default: return {31'd0, q2};
      endcase
   endfunction

   function automatic logic act_w(int i);
      case (i)
         0:       return w0;
         1:       return w1;
         default: return w2;
      endcase
   endfunction

   function automatic logic act_tc(int i);
      case (i)
         0:       return tc0;
         1:       return tc1;
         default: return tc2;
      endcase
   endfunction

   function automatic logic model_tc(int i);
      return en && ((up && mq[i] == MODS[i] - 1) || (!up && mq[i] == 0));
   endfunction

   // One clock edge of the counting rules, in plain integer arithmetic
   function automatic void model_edge();
      for (int i = 0; i < 3; i++) begin
         int m;
         int d;
         bit crossing;
         m = MODS[i];
         d = int'(din) % (1 << WIDS[i]);
         if (clr) begin
            mq[i] = 0;
            mw[i] = 1'b0;
         end else if (load) begin
            mq[i] = (d < m) ? d : m - 1;
            mw[i] = 1'b0;
         end else if (en) begin
            crossing = up ? (mq[i] + 1 >= m) : (mq[i] - 1 < 0);
`ifdef COUNTER_SATURATE_EN
            if (!crossing) mq[i] = up ? mq[i] + 1 : mq[i] - 1;
`else
            mq[i] = up ? (mq[i] + 1) % m : (mq[i] + m - 1) % m;
`endif
            mw[i] = crossing;
         end else begin
            mw[i] = 1'b0;
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; din = 4'd0;
      for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 1'b0; end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (act_q(i) !== 32'd0 || act_w(i) !== 1'b0 || act_tc(i) !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: got q=%0d wrap=%b tc=%b, need q=0 wrap=0 tc=0",
                     i, act_q(i), act_w(i), act_tc(i));
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_up_count();
      logic [31:0] exp0;
      clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_tc(i) !== model_tc(i)) begin
               errors++;
               $display("FAIL up_tc dut%0d cyc%0d: got %b need %b", i, c, act_tc(i), model_tc(i));
            end
         end
         step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_q(i) !== 32'(mq[i]) || act_w(i) !== mw[i]) begin
               errors++;
               $display("FAIL up_count dut%0d cyc%0d: got q=%0d wrap=%b need q=%0d wrap=%b",
                        i, c, act_q(i), act_w(i), mq[i], mw[i]);
            end
         end
      end
`ifdef COUNTER_SATURATE_EN
      exp0 = 32'd9;
`else
      exp0 = 32'd2;
`endif
      checks++;
      if (act_q(0) !== exp0) begin
         errors++;
         $display("FAIL up_final q: got %0d need %0d", act_q(0), exp0);
      end
   endtask

   task automatic test_down_wrap();
      logic [31:0] exp0;
      load = 1'b1; din = 4'd2; en = 1'b0;
      step();
      load = 1'b0; en = 1'b1; up = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_tc(i) !== model_tc(i)) begin
               errors++;
               $display("FAIL down_tc dut%0d cyc%0d: got %b need %b", i, c, act_tc(i), model_tc(i));
            end
         end
         step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_q(i) !== 32'(mq[i]) || act_w(i) !== mw[i]) begin
               errors++;
               $display("FAIL down_count dut%0d cyc%0d: got q=%0d wrap=%b need q=%0d wrap=%b",
                        i, c, act_q(i), act_w(i), mq[i], mw[i]);
            end
         end
      end
`ifdef COUNTER_SATURATE_EN
      exp0 = 32'd0;
`else
      exp0 = 32'd8;
`endif
      checks++;
      if (act_q(0) !== exp0) begin
         errors++;
         $display("FAIL down_final q: got %0d need %0d", act_q(0), exp0);
      end
   endtask

   task automatic test_load_clamp();
      clr = 1'b0; load = 1'b1; en = 1'b1; up = 1'b1; din = 4'd13;
      step();
      checks++;
      if (act_q(0) !== 32'd9 || act_w(0) !== 1'b0) begin
         errors++;
         $display("FAIL load_clamp: got q=%0d wrap=%b need q=9 wrap=0", act_q(0), act_w(0));
      end
      clr = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (act_q(i) !== 32'd0 || act_w(i) !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority dut%0d: got q=%0d wrap=%b need q=0 wrap=0",
                     i, act_q(i), act_w(i));
         end
      end
      clr = 1'b0; load = 1'b0;
   endtask

   task automatic test_async_reset();
      clr = 1'b1; load = 1'b0; en = 1'b0;
      step();
      clr = 1'b0; en = 1'b1; up = 1'b1;
      repeat (7) step();
      checks++;
      if (act_q(0) !== 32'(mq[0])) begin
         errors++;
         $display("FAIL pre_reset q: got %0d need %0d", act_q(0), mq[0]);
      end
      #2;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 1'b0; end
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (act_q(i) !== 32'd0 || act_w(i) !== 1'b0) begin
            errors++;
            $display("FAIL async_reset dut%0d: got q=%0d wrap=%b need q=0 wrap=0",
                     i, act_q(i), act_w(i));
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (act_q(0) !== 32'd0) begin
         errors++;
         $display("FAIL reset_hold q: got %0d need 0", act_q(0));
      end
      reset = 1'b1;
      repeat (2) begin
         step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_q(i) !== 32'(mq[i]) || act_w(i) !== mw[i]) begin
               errors++;
               $display("FAIL resume dut%0d: got q=%0d wrap=%b need q=%0d wrap=%b",
                        i, act_q(i), act_w(i), mq[i], mw[i]);
            end
         end
      end
   endtask

   task automatic test_bounds();
      for (int pass = 0; pass < 2; pass++) begin
         load = 1'b1; en = 1'b0; din = (pass == 0) ? 4'd8 : 4'd1;
         step();
         load = 1'b0; en = 1'b1; up = (pass == 0);
         for (int c = 0; c < 3; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (act_q(i) !== 32'(mq[i]) || act_w(i) !== mw[i]) begin
                  errors++;
                  $display("FAIL bounds p%0d dut%0d cyc%0d: got q=%0d wrap=%b need q=%0d wrap=%b",
                           pass, i, c, act_q(i), act_w(i), mq[i], mw[i]);
               end
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         clr  = ($urandom_range(0, 15) == 0);
         load = ($urandom_range(0, 7) == 0);
         en   = ($urandom_range(0, 3) != 0);
         up   = 1'($urandom_range(0, 1));
         din  = 4'($urandom_range(0, 15));
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_tc(i) !== model_tc(i)) begin
               errors++;
               $display("FAIL rand_tc dut%0d cyc%0d: got %b need %b", i, c, act_tc(i), model_tc(i));
            end
         end
         step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_q(i) !== 32'(mq[i]) || act_w(i) !== mw[i]) begin
               errors++;
               $display("FAIL rand dut%0d cyc%0d: got q=%0d wrap=%b need q=%0d wrap=%b",
                        i, c, act_q(i), act_w(i), mq[i], mw[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down_wrap();
      test_load_clamp();
      test_async_reset();
      test_bounds();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
